// File: rtl/regfile_dump.sv
// regfile_dump: walks the register file pair by pair and streams {addr, data} words over valid/ready.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rs1,
  output logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int P_W = ADDR_W - 1;
  localparam logic [P_W-1:0] P_LAST = P_W'(NUM_REGS / 2 - 1);
  typedef enum logic [2:0] {IDLE, FETCH, SEND_LO, SEND_HI, DONE} state_t;
  state_t state;
  logic [P_W-1:0] p;
  logic [DATA_W-1:0] hi;
  assign rs1 = {p, 1'b0};
  assign rs2 = {p, 1'b1};
  // the even word goes straight into out_data at FETCH; only the odd word needs holding
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      p         <= '0;
      hi        <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      p         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else
      case (state)
        IDLE, DONE: if (start) begin
          state <= FETCH;
          p     <= '0;
          busy  <= 1'b1;
          done  <= 1'b0;
        end
        FETCH: begin
          hi        <= read_data2;
          out_data  <= read_data1;
          out_addr  <= {p, 1'b0};
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          state     <= SEND_LO;
        end
        SEND_LO: if (out_ready) begin
          out_addr <= {p, 1'b1};
          out_data <= hi;
          out_last <= (p == P_LAST);
          state    <= SEND_HI;
        end
        SEND_HI: if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (out_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            p     <= p + P_W'(1);
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: scoreboard-checked dumps under several ready patterns, races, abort and reset.
module tb_regfile_dump;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, out_ready = 0;
  logic [4:0] rs1, rs2, out_addr;
  logic [31:0] read_data1, read_data2, out_data;
  logic out_valid, out_last, busy, done;
  logic [31:0] rf [32];
  int checks = 0, errors = 0, xfers = 0;
  typedef struct packed {logic [4:0] a; logic [31:0] d; logic l;} exp_t;
  exp_t q[$];
  typedef struct {logic [3:0] pat; int cycles; int mode;} vec_t;
  vec_t vecs [5];
  logic stall = 0;
  logic [4:0] s_addr;
  logic [31:0] s_data;

  regfile_dump dut (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rs1(rs1), .rs2(rs2),
    .read_data1(read_data1), .read_data2(read_data2), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last), .busy(busy), .done(done));

  always #5 clk = ~clk;
  assign read_data1 = rf[rs1];
  assign read_data2 = rf[rs2];

  always @(negedge clk) begin
    if (rst_n && stall && out_valid) begin
      checks++;
      if (out_addr !== s_addr || out_data !== s_data) begin
        errors++;
        $display("FAIL stall_stable got %0d/%h want %0d/%h", out_addr, out_data, s_addr, s_data);
      end
    end
    stall = rst_n && out_valid && !out_ready && !abort;
    s_addr = out_addr;
    s_data = out_data;
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      xfers++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL extra_word got addr %0d data %h want none", out_addr, out_data);
      end else begin
        e = q.pop_front();
        if ({out_addr, out_data, out_last} !== {e.a, e.d, e.l}) begin
          errors++;
          $display("FAIL word got %0d/%h/%b want %0d/%h/%b", out_addr, out_data, out_last, e.a, e.d, e.l);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic init_rf();
    for (int i = 0; i < 32; i++) rf[i] = i * 3 + 7;
  endtask

  task automatic push_all(input int mode);
    for (int i = 0; i < 32; i++)
      q.push_back('{a: 5'(i), d: (mode == 1 && i == 20) ? 32'hBEEF : rf[i], l: (i == 31)});
  endtask

  task automatic kick();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run(input logic [3:0] pat, input int exp_cycles, input int mode);
    int n = 0;
    bit hooked = 0;
    xfers = 0;
    q.delete();
    push_all(mode);
    kick();
    while (!done && n < 2000) begin
      start = 0;
      out_ready = pat[n % 4];
      if (!hooked && mode == 1 && out_valid && out_addr == 12) begin
        rf[12] = 32'hDEAD;
        rf[20] = 32'hBEEF;
        hooked = 1;
      end
      if (!hooked && mode == 2 && out_valid && out_addr == 8) begin
        start = 1;
        hooked = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 0;
    out_ready = 0;
    chk("done_reached", 32'(done), 32'd1);
    if (exp_cycles != 0) chk("dump_cycles", n, exp_cycles);
    chk("xfer_count", xfers, 32'd32);
    chk("queue_empty", q.size(), 32'd0);
  endtask

  task automatic wait_addr(input logic [4:0] a);
    int n = 0;
    while (!(out_valid && out_addr == a) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_addr_reached", 32'(out_valid && out_addr == a), 32'd1);
  endtask

  initial begin
    vecs[0] = '{4'b1111, 48, 0};
    vecs[1] = '{4'b1001, 0, 0};
    vecs[2] = '{4'b0101, 0, 0};
    vecs[3] = '{4'b1111, 48, 1};
    vecs[4] = '{4'b1111, 48, 2};
    init_rf();
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_rs1", 32'(rs1), 0);
    chk("rst_rs2", 32'(rs2), 1);
    chk("rst_busy_done", 32'({busy, done, out_last}), 0);
    chk("rst_out", 32'(out_addr) | out_data, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    for (int v = 0; v < 5; v++) begin
      init_rf();
      run(vecs[v].pat, vecs[v].cycles, vecs[v].mode);
      chk("busy_after_dump", 32'(busy), 0);
    end
    init_rf();
    q.delete();
    push_all(0);
    kick();
    chk("busy_in_fetch", 32'(busy), 1);
    chk("rs_in_fetch", 32'({rs1, rs2}), 32'({5'd0, 5'd1}));
    out_ready = 1;
    wait_addr(5'd7);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    out_ready = 0;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_rs1", 32'(rs1), 0);
    chk("abort_busy_done", 32'({busy, done}), 0);
    chk("abort_consumed", q.size(), 24);
    @(posedge clk); #1;
    chk("idle_stays", 32'(busy), 0);
    run(4'b1111, 48, 0);
    q.delete();
    push_all(0);
    kick();
    out_ready = 1;
    wait_addr(5'd11);
    out_ready = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_rs", 32'({rs1, rs2}), 32'({5'd0, 5'd1}));
    chk("mid_rst_busy_done", 32'({busy, done, out_last}), 0);
    @(posedge clk); #1;
    chk("mid_rst_held", 32'(out_valid | busy), 0);
    rst_n = 1;
    q.delete();
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(out_valid | busy | done), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential reader for the 32×32 register file. On `start` it walks every register address and streams `{address, data}` words out over a valid/ready handshake. It drives the register file's two combinational read ports (`rs1`, `rs2`) and fetches one even/odd register pair per fetch cycle. It sits beside the register file, opposite the write port, and feeds a debug/trace sink or a checker.

## Interface
- `NUM_REGS`, 32: number of registers walked; must be even, at least 2.
- `ADDR_W`, 5: register address width, equal to clog2(`NUM_REGS`).
- `DATA_W`, 32: register data width.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle request to begin a dump; only honoured in IDLE or DONE.
- `abort`, input, 1: synchronous cancel; the dump returns to IDLE on the next edge.
- `rs1`, output, `ADDR_W`: read address to register file port 1; always the even address of the current pair.
- `rs2`, output, `ADDR_W`: read address to register file port 2; always the odd address (`rs1`+1).
- `read_data1`, input, `DATA_W`: combinational read data for `rs1`.
- `read_data2`, input, `DATA_W`: combinational read data for `rs2`.
- `out_valid`, output, 1: output word available.
- `out_ready`, input, 1: sink accepts the word. A transfer happens when `out_valid` and `out_ready` are both high at the rising edge.
- `out_addr`, output, `ADDR_W`: register index of the current output word.
- `out_data`, output, `DATA_W`: register contents of the current output word.
- `out_last`, output, 1: high with the word for register `NUM_REGS`-1.
- `busy`, output, 1: high in FETCH, SEND_LO and SEND_HI.
- `done`, output, 1: high in DONE. Stays high until the next `start` or `abort`.

## Operation
- Reset value of every output:
  - `rs1`=0, `rs2`=1
  - `out_valid`=0, `out_addr`=0, `out_data`=0, `out_last`=0
  - `busy`=0, `done`=0
  - Internal state: state=IDLE, pair index=0, both capture registers=0.
- The pair index `p` is a register of width `ADDR_W`-1. `rs1` = {p,0} and `rs2` = {p,1}, both driven from the register (no combinational path from inputs).
- FSM states and transitions:
  - IDLE: `start` → FETCH, with p=0.
  - FETCH: `read_data1` and `read_data2` are captured into lo/hi buffers → SEND_LO. FETCH always lasts exactly 1 cycle.
  - SEND_LO: `out_valid`=1, `out_addr`={p,0}, `out_data`=lo buffer. On handshake → SEND_HI.
  - SEND_HI: `out_valid`=1, `out_addr`={p,1}, `out_data`=hi buffer, `out_last`=(p==`NUM_REGS`/2-1). On handshake:
    - if last → DONE;
    - else p increments by 1 → FETCH.
  - DONE: `start` → FETCH, with p=0. `abort` → IDLE.
- `abort` has priority over every transition, including a handshake in the same cycle. That handshake still counts as a consumed transfer at the sink, but the FSM goes to IDLE with p=0 and drops `out_valid` on the next cycle.
- `start` is ignored in FETCH, SEND_LO and SEND_HI.
- `out_valid`, once high, stays high with `out_addr`/`out_data` stable until the handshake. `abort` is the only exception.
- Register-file writes during a dump are not blocked:
  - The captured value is whatever the register file returned in the FETCH cycle.
  - A write to a pair that has already been captured does not appear in the output.
- The p increment wraps nowhere: it happens only on non-last SEND_HI handshakes.

## Timing
- `start` is sampled at edge E0. FETCH is the cycle after E0, with `rs1`/`rs2` already valid. `out_valid` rises after edge E1, so first word latency is 2 cycles from the `start` edge.
- With `out_ready` held high, each pair takes 3 cycles (FETCH, SEND_LO, SEND_HI).
  - A full dump of 32 registers takes 16×3 = 48 cycles from E0 to DONE.
  - 32 words transfer; throughput is 2 words per 3 cycles.
- `out_ready` low stalls in SEND_LO or SEND_HI indefinitely, with no data change.
- `rst_n` asserted mid-dump forces all outputs to their reset values immediately (asynchronously). There is no partial output after reset.
- `busy` and `done` are registered state decodes, aligned with the FSM state.

## Test plan
- Reset then idle: hold `rst_n`=0 mid-dump (state SEND_HI, p=5) → on the next cycle `out_valid`=0, `rs1`=0, `rs2`=1, `busy`=0, `done`=0.
- Full dump, `out_ready`=1: register file preloaded with reg[i]=i×3+7, pulse `start` → 32 transfers with `out_addr` 0..31 and data 7, 10, …, 100. `out_last` is high only on addr 31. `done` rises at cycle 48 after the `start` edge.
- Backpressure: `out_ready` toggles 1,0,0,1 repeatedly → identical word sequence to the full dump. `out_data` is stable during every stall; no word is dropped or duplicated.
- Abort mid-stream: `abort` asserted in SEND_HI at p=3, coincident with a handshake → next cycle IDLE, `out_valid`=0, `rs1`=0. A subsequent `start` restarts from addr 0.
- Write race: after `start`, write reg[12]=0xDEAD once the pair-6 FETCH has passed, and write reg[20]=0xBEEF before the pair-10 FETCH → output shows the old reg[12] and 0xBEEF for reg[20].
- Start ignored while busy: pulse `start` during SEND_LO at p=4 → the sequence continues to addr 31 unchanged, with exactly 32 transfers total.
